// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory request and IF/ID pipeline register.
// A BOOT cycle after reset precedes fetching; redirects use jump over branch priority.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Redirect targets are word-aligned by dropping the low two bits.
  always_comb begin
    redirect = jump | branch_taken;
    target   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state != BOOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= BOOT;
      ifid_instr <= 32'h0000_0000;
      ifid_pc4   <= 32'h0000_0000;
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (redirect) begin
            pc <= target;
          end
        end
        FETCH, WAIT: begin
          if (redirect) begin
            pc         <= target;
            state      <= FETCH;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            if (imem_ready) begin
              pc         <= pc_plus4;
              state      <= FETCH;
              ifid_instr <= imem_rdata;
              ifid_pc4   <= pc_plus4;
              ifid_valid <= 1'b1;
            end else begin
              state      <= WAIT;
              ifid_valid <= 1'b0;
            end
          end
          // Flush turns IF/ID into a NOP bubble regardless of stall or capture.
          if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0000_0000;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] WORD = 32'h2001_0005;

  instr_fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc), .imem_addr(imem_addr), .imem_req(imem_req),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: the model only knows "still in the boot cycle" vs "fetching".
  logic        m_known = 1'b0;
  logic        m_boot;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  always @(posedge clk) begin
    logic [31:0] dest;
    dest = jump ? (jump_target & 32'hFFFF_FFFC) : (branch_target & 32'hFFFF_FFFC);
    if (rst) begin
      m_known = 1'b1;
      m_boot  = 1'b1;
      m_pc    = RPC;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (m_known) begin
      if (m_boot) begin
        m_boot = 1'b0;
        if (jump || branch_taken) m_pc = dest;
      end else begin
        if (jump || branch_taken) begin
          m_pc    = dest;
          m_valid = 1'b0;
        end else if (!stall && imem_ready) begin
          m_instr = imem_rdata;
          m_pc4   = m_pc + 32'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end else if (!stall) begin
          m_valid = 1'b0;
        end
        if (flush) begin
          m_valid = 1'b0;
          m_instr = 32'h0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negedge the DUT outputs are compared with the model.
  always @(negedge clk) begin
    if (m_known) begin
      checkOutput("pc", pc, m_pc);
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, !m_boot});
      checkOutput("ifid_instr", ifid_instr, m_instr);
      checkOutput("ifid_pc4", ifid_pc4, m_pc4);
      checkOutput("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt,
                               input logic [31:0] rd, input logic rdy);
    rst = r; stall = s; flush = f;
    branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    imem_rdata = rd; imem_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    $display("[TB] start");
    // Reset, then straight-line fetch with memory always ready.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("rst_pc", pc, RPC);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("rst_pc4", ifid_pc4, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("c2_req", {31'b0, imem_req}, 32'd1);
    checkOutput("c2_addr", imem_addr, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("c3_valid", {31'b0, ifid_valid}, 32'd1);
    checkOutput("c3_pc4", ifid_pc4, 32'd4);
    checkOutput("c3_pc", pc, 32'd4);
    checkOutput("c3_instr", ifid_instr, WORD);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("seq_pc", pc, 32'd8);

    // Memory not ready for three cycles at pc=8.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 0);
      checkOutput("wait_addr", imem_addr, 32'd8);
      checkOutput("wait_valid", {31'b0, ifid_valid}, 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("wait_done_pc4", ifid_pc4, 32'd12);
    checkOutput("wait_done_valid", {31'b0, ifid_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);

    // Two stall cycles at pc=16 hold everything.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
      checkOutput("stall_pc", pc, 32'd16);
      checkOutput("stall_pc4", ifid_pc4, 32'd16);
      checkOutput("stall_instr", ifid_instr, WORD);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("resume_pc4", ifid_pc4, 32'd20);

    // Jump beats branch, and redirect beats stall.
    applyStimulus(0, 1, 0, 1, 32'h200, 1, 32'h400, WORD, 1);
    checkOutput("redir_pc", pc, 32'h400);
    checkOutput("redir_valid", {31'b0, ifid_valid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);

    // Flush with stall: bubble in IF/ID, pc held.
    applyStimulus(0, 1, 1, 0, 0, 0, 0, WORD, 1);
    checkOutput("flush_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("flush_instr", ifid_instr, 32'd0);
    checkOutput("flush_pc", pc, 32'h404);

    // Misaligned jump target gets its low bits cleared, then pc wraps.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, WORD, 1);
    checkOutput("align_pc", pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 1);
    checkOutput("wrap_pc", pc, 32'd0);
    checkOutput("wrap_pc4", ifid_pc4, 32'd0);

    // Reset during a wait at pc=0x40.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h40, WORD, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, WORD, 0);
    checkOutput("pre_rst_addr", imem_addr, 32'h40);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, WORD, 0);
    checkOutput("midrst_pc", pc, RPC);
    checkOutput("midrst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midrst_valid", {31'b0, ifid_valid}, 32'd0);

    // Randomized traffic; the negedge compare process does the checking.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] bt, jt;
      bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      jt = $urandom;
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, bt,
                    $urandom_range(0, 9) == 0, jt,
                    $urandom,
                    $urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] must be 0).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 SHALL have port stall  input  1  hazard hold from decode; freezes PC and IF/ID register.
REQ-005 SHALL have port flush  input  1  kills the IF/ID contents (bubble insert).
REQ-006 SHALL have port branch_taken  input  1  redirect PC to branch_target.
REQ-007 SHALL have port branch_target  input  32  branch destination address.
REQ-008 SHALL have port jump  input  1  redirect PC to jump_target.
REQ-009 SHALL have port jump_target  input  32  jump destination address.
REQ-010 SHALL have port imem_rdata  input  32  instruction word from memory.
REQ-011 SHALL have port imem_ready  input  1  imem_rdata valid for current imem_addr this cycle.
REQ-012 SHALL have port pc  output  32  current fetch PC, feeding the PC+4 incrementer.
REQ-013 SHALL have port imem_addr  output  32  memory address, always equal to pc.
REQ-014 SHALL have port imem_req  output  1  fetch request.
REQ-015 SHALL have port ifid_instr  output  32  registered instruction to decode.
REQ-016 SHALL have port ifid_pc4  output  32  registered PC+4 of ifid_instr.
REQ-017 SHALL have port ifid_valid  output  1  ifid_instr is a real instruction.

Function
REQ-018 SHALL implement FSM states BOOT, FETCH, WAIT, all outputs registered except imem_addr and imem_req, which decode from pc/state.
REQ-019 SHALL hold imem_req=0 in BOOT and imem_req=1 in FETCH and WAIT.
REQ-020 SHALL transition BOOT->FETCH unconditionally after one cycle.
REQ-021 In FETCH/WAIT with imem_ready=1, no stall, no redirect: SHALL load ifid_instr<=imem_rdata, ifid_pc4<=pc+4 (mod 2^32), ifid_valid<=1, pc<=pc+4, next state FETCH.
REQ-022 In FETCH/WAIT with imem_ready=0, no stall, no redirect: SHALL hold pc, set ifid_valid<=0, next state WAIT.
REQ-023 Redirect priority SHALL be jump over branch_taken; target bits [1:0] SHALL be forced to 2'b00.
REQ-024 On redirect in FETCH/WAIT: pc<=target, next state FETCH, any imem_rdata that cycle discarded, ifid_valid<=0 (redirect wins over stall).
REQ-025 On stall without redirect: pc, ifid_instr, ifid_pc4, ifid_valid SHALL hold; imem_rdata returned that cycle discarded; state FETCH/WAIT retained.
REQ-026 On flush: ifid_valid<=0 and ifid_instr<=32'h0000_0000 (NOP); flush SHALL override stall for IF/ID; pc update follows REQ-021..REQ-025 independently.
REQ-027 Redirect or flush in BOOT SHALL be ignored except that a redirect loads pc.
REQ-028 pc wrap: 32'hFFFF_FFFC+4 SHALL yield 32'h0000_0000, no error flag.
REQ-029 imem_addr SHALL remain stable while in WAIT with no redirect.

Reset
REQ-030 On rst=1 at posedge: pc<=RESET_PC, state<=BOOT, ifid_instr<=0, ifid_pc4<=0, ifid_valid<=0, overriding all other inputs.
REQ-031 Reset asserted mid-fetch (WAIT) SHALL discard the outstanding request; imem_req=0 the following cycle.

Verification
REQ-032 Reset then imem_ready=1 constant, rdata=32'h2001_0005 -> cycle1 imem_req=0 (BOOT), cycle2 addr 0, cycle3 ifid_valid=1, ifid_pc4=4, pc=4, sequential thereafter.
REQ-033 imem_ready low 3 cycles at pc=8 -> imem_addr=8 held, ifid_valid=0 for 3 cycles, then instruction captured with ifid_pc4=12.
REQ-034 stall=1 for 2 cycles at pc=16 -> pc stays 16, IF/ID unchanged, fetch resumes at 16 after release.
REQ-035 jump=1 (target 32'h0000_0400) and branch_taken=1 (target 32'h0000_0200) same cycle, plus stall=1 -> pc=32'h400, ifid_valid=0.
REQ-036 flush=1 with stall=1 -> ifid_valid=0, ifid_instr=0, pc held; pc=32'hFFFF_FFFC fetched -> next pc=0.
REQ-037 rst=1 during WAIT at pc=32'h40 -> next cycle pc=RESET_PC, imem_req=0, ifid_valid=0.
